// File: rtl/nbit_reg_serializer.sv
// N-bit parallel-to-serial unloader with en/ready load handshake and a one-cycle done pulse.
// Optional feature: define PARITY_EN to append an even-parity bit after the data bits.
module nbit_reg_serializer #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] din,
    output logic         ready,
    output logic         busy,
    output logic         sout,
    output logic         sout_valid,
    output logic         done
);

`ifdef PARITY_EN
    localparam int NB = N + 1;
`else
    localparam int NB = N;
`endif
    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);
`ifdef PARITY_EN
    localparam logic [CW-1:0] PAR_CNT = CW'(N - 1);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_r;
    logic [N-1:0]  shreg_r;
    logic [CW-1:0] cnt_r;
`ifdef PARITY_EN
    logic          par_r;
`endif

    function automatic logic out_bit(input logic [N-1:0] w);
        return MSB_FIRST ? w[N-1] : w[0];
    endfunction

    // Moves the next bit to the output end; vacated bits fill with zero.
    function automatic logic [N-1:0] shift_word(input logic [N-1:0] w);
        return MSB_FIRST ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
    endfunction

`ifdef PARITY_EN
    function automatic logic even_parity(input logic [N-1:0] w);
        return ^w;
    endfunction
`endif

    // Handshake FSM, shift datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            shreg_r    <= '0;
            cnt_r      <= '0;
`ifdef PARITY_EN
            par_r      <= 1'b0;
`endif
            ready      <= 1'b1;
            busy       <= 1'b0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (en) begin
                        // The first bit goes straight to sout; the register keeps the rest.
                        shreg_r    <= shift_word(din);
                        cnt_r      <= '0;
`ifdef PARITY_EN
                        par_r      <= even_parity(din);
`endif
                        sout       <= out_bit(din);
                        sout_valid <= 1'b1;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                        state_r    <= SHIFT;
                    end else begin
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        ready      <= 1'b1;
                        busy       <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                SHIFT: begin
                    if (cnt_r == LAST_CNT) begin
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        done       <= 1'b1;
                        state_r    <= DONE;
                    end else begin
                        cnt_r      <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        shreg_r    <= shift_word(shreg_r);
                        sout_valid <= 1'b1;
`ifdef PARITY_EN
                        if (cnt_r == PAR_CNT) begin
                            sout <= par_r;
                        end else begin
                            sout <= out_bit(shreg_r);
                        end
`else
                        sout       <= out_bit(shreg_r);
`endif
                        state_r    <= SHIFT;
                    end
                end
                DONE: begin
                    done       <= 1'b0;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    ready      <= 1'b1;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    done       <= 1'b0;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    ready      <= 1'b1;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nbit_reg_serializer.sv
// Bench for nbit_reg_serializer: constant vector table, hand-written reset/MSB sequences,
// and random traffic checked against a sequence-position reference model (LSB- and MSB-first DUTs).
module tb_nbit_reg_serializer;
    localparam int N = 4;
`ifdef PARITY_EN
    localparam int NB = N + 1;
    localparam bit PAR = 1'b1;
`else
    localparam int NB = N;
    localparam bit PAR = 1'b0;
`endif
    // Output vectors are {ready, busy, sout, sout_valid, done}.
    localparam logic [4:0] IDLE_O = 5'b10000;
    localparam logic [4:0] DONE_O = 5'b01001;

    logic clk = 1'b0;
    logic reset, en;
    logic [N-1:0] din;
    logic ready_l, busy_l, sout_l, valid_l, done_l;
    logic ready_m, busy_m, sout_m, valid_m, done_m;
    logic [4:0] out_l, out_m;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic         en;
        logic [N-1:0] din;
        logic [4:0]   exp;
    } vec_t;
    vec_t tbl[$];

    // Model state per DUT: -1 idle, 0..NB-1 bit index on the line, NB = done cycle.
    int         pos[2];
    logic [N-1:0] word[2];

    always #5 clk = ~clk;

    nbit_reg_serializer #(.N(N), .MSB_FIRST(1'b0)) dut (
        .clk(clk), .reset(reset), .en(en), .din(din),
        .ready(ready_l), .busy(busy_l), .sout(sout_l), .sout_valid(valid_l), .done(done_l)
    );

    nbit_reg_serializer #(.N(N), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .en(en), .din(din),
        .ready(ready_m), .busy(busy_m), .sout(sout_m), .sout_valid(valid_m), .done(done_m)
    );

    assign out_l = {ready_l, busy_l, sout_l, valid_l, done_l};
    assign out_m = {ready_m, busy_m, sout_m, valid_m, done_m};

    function automatic logic [4:0] bitrec(input logic b);
        return {2'b01, b, 1'b1, 1'b0};
    endfunction

    function automatic logic [4:0] rec(input logic [N-1:0] w, input bit msb, input int p);
        if (p < 0) return IDLE_O;
        if (p < N) return bitrec(msb ? w[N-1-p] : w[p]);
        if (PAR && p == N) return bitrec(^w);
        return DONE_O;
    endfunction

    task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b (ready,busy,sout,valid,done) t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                pos[k] = -1;
            end else if (pos[k] < 0) begin
                if (en) begin
                    pos[k]  = 0;
                    word[k] = din;
                end
            end else begin
                pos[k]++;
                if (pos[k] > NB) pos[k] = -1;
            end
        end
    endtask

    task automatic step(input string nm);
        @(posedge clk);
        #1;
        model_edge();
        check({nm, "_lsb"}, out_l, rec(word[0], 1'b0, pos[0]));
        check({nm, "_msb"}, out_m, rec(word[1], 1'b1, pos[1]));
    endtask

    task automatic add(input logic e, input logic [N-1:0] d, input logic [4:0] x);
        vec_t v;
        v.en = e; v.din = d; v.exp = x;
        tbl.push_back(v);
    endtask

    initial begin
        pos[0] = -1; pos[1] = -1; word[0] = '0; word[1] = '0;
`ifdef PARITY_EN
        add(1'b1, 4'b1011, bitrec(1'b1));
        add(1'b0, 4'b0000, bitrec(1'b1));
        add(1'b0, 4'b0000, bitrec(1'b0));
        add(1'b0, 4'b0000, bitrec(1'b1));
        add(1'b0, 4'b0000, bitrec(1'b1));
        add(1'b0, 4'b0000, DONE_O);
        add(1'b0, 4'b0000, IDLE_O);
`else
        add(1'b1, 4'b0001, bitrec(1'b1));
        add(1'b0, 4'b0000, bitrec(1'b0));
        add(1'b0, 4'b0000, bitrec(1'b0));
        add(1'b0, 4'b0000, bitrec(1'b0));
        add(1'b0, 4'b0000, DONE_O);
        add(1'b0, 4'b0000, IDLE_O);
        add(1'b1, 4'b1000, bitrec(1'b0));
        add(1'b1, 4'b1111, bitrec(1'b0));
        add(1'b1, 4'b1111, bitrec(1'b0));
        add(1'b1, 4'b1111, bitrec(1'b1));
        add(1'b1, 4'b1111, DONE_O);
        add(1'b1, 4'b1111, IDLE_O);
        add(1'b1, 4'b1111, bitrec(1'b1));
        add(1'b0, 4'b0000, bitrec(1'b1));
        add(1'b0, 4'b0000, bitrec(1'b1));
        add(1'b0, 4'b0000, bitrec(1'b1));
        add(1'b0, 4'b0000, DONE_O);
        add(1'b0, 4'b0000, IDLE_O);
`endif

        // Reset takes effect before any clock edge and holds for two cycles.
        reset = 1'b1; en = 1'b0; din = '0;
        #1;
        check("reset_async_lsb", out_l, IDLE_O);
        check("reset_async_msb", out_m, IDLE_O);
        step("reset_hold");
        step("reset_hold");
        reset = 1'b0;
        step("post_reset");

        foreach (tbl[i]) begin
            en  = tbl[i].en;
            din = tbl[i].din;
            step("table_model");
            check($sformatf("table_row%0d", i), out_l, tbl[i].exp);
        end

        // Reset during the second bit discards the word with no done pulse.
        en = 1'b1; din = 4'b1010;
        step("midreset_load");
        en = 1'b0;
        step("midreset_bit2");
        #2;
        reset = 1'b1;
        #1;
        check("midreset_now_lsb", out_l, IDLE_O);
        check("midreset_now_msb", out_m, IDLE_O);
        step("midreset_hold");
        reset = 1'b0;
        for (int i = 0; i < NB + 2; i++) step("midreset_nodone");
        en = 1'b1; din = 4'b0110;
        step("reload_0110");
        en = 1'b0;
        for (int i = 0; i < NB + 2; i++) step("reload_0110");

        // MSB-first ordering.
        en = 1'b1; din = 4'b1000;
        step("msb_1000");
        check("msb_1000_first", {4'b0000, sout_m}, 5'b00001);
        en = 1'b0;
        for (int i = 0; i < NB + 1; i++) step("msb_1000");
        en = 1'b1; din = 4'b0001;
        step("msb_0001");
        check("msb_0001_first", {4'b0000, sout_m}, 5'b00000);
        en = 1'b0;
        for (int i = 0; i < NB + 1; i++) step("msb_0001");

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            din   = 4'($urandom);
            reset = ($urandom_range(0, 59) == 0);
            step("random");
            reset = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
